// File: rtl/decompressor_pkg.sv
// Shared types and constants for the fetch/decompress front end.
package decompressor_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;

  // Wide enough for any supported WIDTH; users cast down to their width.
  localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;
  localparam logic [31:0] PCADD_DEFAULT   = 32'h4;

endpackage

// File: rtl/fetch_fifo.sv
// Small {instr, pc} FIFO between the memory fetch FSM and the decompressor.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_instr,
  input  logic [WIDTH-1:0]         push_pc,
  output logic [WIDTH-1:0]         head_instr,
  output logic [WIDTH-1:0]         head_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{instr: push_instr, pc: push_pc};
  end

  // Gate the head with occupancy so reset/flush show zeros, never stale words.
  assign head_instr = (count != '0) ? mem[rd_ptr].instr : '0;
  assign head_pc    = (count != '0) ? mem[rd_ptr].pc    : '0;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch: one outstanding memory fetch feeding a small FIFO.
// Optional FETCH_PERF_EN adds a saturating decompressor-starvation counter.
module fetch_prefetch_buffer
  import decompressor_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] PCADD    = WIDTH'(PCADD_DEFAULT),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_pc,
  output logic                   mem_req,
  output logic [WIDTH-1:0]       mem_addr,
  input  logic                   mem_ack,
  input  logic [WIDTH-1:0]       mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_instr,
  output logic [WIDTH-1:0]       out_pc,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            starve_cnt
`endif
);
  localparam int               CW    = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] ALIGN = WIDTH'(WORD_ALIGN_MASK);

  fetch_state_t     state, state_nxt;
  logic [WIDTH-1:0] fetch_pc, fetch_pc_nxt, mem_addr_nxt;
  logic             push, pop;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      mem_addr <= mem_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_addr_nxt = mem_addr;
    push         = 1'b0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        mem_addr_nxt = fetch_pc;
        // Hold off one cycle on redirect so mem_addr picks up the new PC first.
        if (!redirect && ((count < CW'(DEPTH)) || pop)) state_nxt = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (redirect) begin
          state_nxt = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + PCADD;
          if (pop || (count < CW'(DEPTH - 1))) mem_addr_nxt = fetch_pc + PCADD;
          else                                 state_nxt    = IDLE;
        end
      end
      DISCARD: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) fetch_pc_nxt = redirect_pc & ALIGN;
  end

  fetch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_instr (mem_rdata),
    .push_pc    (mem_addr),
    .head_instr (out_instr),
    .head_pc    (out_pc),
    .count      (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (!out_valid && out_ready && !redirect && (starve_cnt != '1))
      starve_cnt <= starve_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: streaming, backpressure, redirects, PC wrap, reset.
module tb_fetch_prefetch_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;
  logic        ack_en;
`ifdef FETCH_PERF_EN
  logic [31:0] starve_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Memory model: acks the same cycle when enabled, data derived from address.
  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  fetch_prefetch_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count)
`ifdef FETCH_PERF_EN
    ,
    .starve_cnt  (starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   32'(mem_req),   32'h0);
    chk({tag, "_addr"},  mem_addr,       32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_instr"}, out_instr,      32'h0);
    chk({tag, "_pc"},    out_pc,         32'h0);
    chk({tag, "_count"}, 32'(count),     32'h0);
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1; ack_en = 1'b1;
    #23;
    chk_zero("rst");
    step();
    reset = 1'b1;                                   // released just after E0

    // Streaming: ack every cycle, ready every cycle
    step();                                         // E1
    chk("s_req", 32'(mem_req), 32'h1);
    chk("s_addr0", mem_addr, 32'h0);
    chk("s_valid0", 32'(out_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin               // E2..E5
      step();
      chk("s_valid", 32'(out_valid), 32'h1);
      chk("s_pc", out_pc, 32'(4 * k));
      chk("s_instr", out_instr, 32'(4 * k) ^ 32'hA5A5_0000);
      chk("s_addr", mem_addr, 32'(4 * k + 4));
      chk("s_count", 32'(count), 32'h1);
    end
`ifdef FETCH_PERF_EN
    chk("starve", starve_cnt, 32'd2);
`endif

    // Backpressure: FIFO fills, fetch idles, one pop restarts fetch
    out_ready = 1'b0;
    step(3);                                        // E8
    chk("bp_count_full", 32'(count), 32'h4);
    chk("bp_req_idle", 32'(mem_req), 32'h0);
    step(7);                                        // E15
    chk("bp_count_hold", 32'(count), 32'h4);
    chk("bp_req_hold", 32'(mem_req), 32'h0);
    chk("bp_head", out_pc, 32'h0000_000C);
    out_ready = 1'b1;
    step();                                         // E16
    chk("bp_reissue_req", 32'(mem_req), 32'h1);
    chk("bp_reissue_addr", mem_addr, 32'h0000_001C);
    chk("bp_count_pop", 32'(count), 32'h3);
    chk("bp_head_next", out_pc, 32'h0000_0010);
    out_ready = 1'b0;
    step();                                         // E17
    chk("bp_refill", 32'(count), 32'h4);
    chk("bp_refill_idle", 32'(mem_req), 32'h0);

    // Redirect during REQ with delayed ack -> DISCARD
    ack_en = 1'b0; out_ready = 1'b1;
    step();                                         // E18
    chk("rd_req", 32'(mem_req), 32'h1);
    chk("rd_addr", mem_addr, 32'h0000_0020);
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    step();                                         // E19
    redirect = 1'b0;
    chk("rd_flush_count", 32'(count), 32'h0);
    chk("rd_flush_valid", 32'(out_valid), 32'h0);
    chk("rd_discard_req", 32'(mem_req), 32'h1);
    chk("rd_discard_addr", mem_addr, 32'h0000_0020);
    step(2);                                        // E21
    chk("rd_discard_hold", mem_addr, 32'h0000_0020);
    ack_en = 1'b1;
    step();                                         // E22: stale data dropped
    chk("rd_drop_req", 32'(mem_req), 32'h0);
    chk("rd_drop_count", 32'(count), 32'h0);
    step();                                         // E23
    chk("rd_new_addr", mem_addr, 32'h0000_1000);
    chk("rd_new_req", 32'(mem_req), 32'h1);
    step();                                         // E24
    chk("rd_new_pc", out_pc, 32'h0000_1000);
    chk("rd_new_instr", out_instr, 32'hA5A5_1000);

    // Redirect coincident with ack, count=2; also exercises PC wrap
    out_ready = 1'b0;
    step();                                         // E25
    chk("ra_count2", 32'(count), 32'h2);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();                                         // E26
    redirect = 1'b0; out_ready = 1'b1;
    chk("ra_count0", 32'(count), 32'h0);
    chk("ra_idle", 32'(mem_req), 32'h0);
    step();                                         // E27
    chk("ra_addr", mem_addr, 32'hFFFF_FFF8);
    step();                                         // E28
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", out_instr, 32'h5A5A_FFF8);
    step();
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step();                                         // E30
    chk("wrap_pc2", out_pc, 32'h0000_0000);
    chk("wrap_instr2", out_instr, 32'hA5A5_0000);

    // Asynchronous reset mid-transaction with count=3
    out_ready = 1'b0;
    step(2);                                        // E32
    chk("ar_count3", 32'(count), 32'h3);
    chk("ar_req", 32'(mem_req), 32'h1);
    reset = 1'b0;
    #1;
    chk_zero("ar");
`ifdef FETCH_PERF_EN
    chk("ar_starve", starve_cnt, 32'd0);
`endif
    step();
    reset = 1'b1;
    step();
    chk("ar_restart_req", 32'(mem_req), 32'h1);
    chk("ar_restart_addr", mem_addr, 32'h0);
    step();
    chk("ar_restart_pc", out_pc, 32'h0);
    chk("ar_restart_count", 32'(count), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
